// File: rtl/ram_arbiter_if.sv
// Port-A request/response and port-B debug bus of the ram_arbiter.
// Channel i of ReqAddr/ReqWData lives at [i*AW +: AW] / [i*DW +: DW].
interface ram_arbiter_if #(
    parameter int DW  = 16,
    parameter int AW  = 15,
    parameter int NCH = 2,
    parameter int LW  = 8
);
    logic [NCH-1:0]    ReqValid;
    logic [NCH-1:0]    ReqWrite;
    logic [NCH*AW-1:0] ReqAddr;
    logic [NCH*DW-1:0] ReqWData;
    logic [NCH-1:0]    ReqReady;
    logic [NCH-1:0]    RspValid;
    logic [DW-1:0]     RspData;
    logic [AW-1:0]     DbgAddr;
    logic [DW-1:0]     DbgData;
    logic              DbgScanStart;
    logic [LW-1:0]     DbgScanLen;
    logic              DbgScanBusy;
    logic              DbgScanValid;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, DbgAddr, DbgScanStart, DbgScanLen,
        input  ReqReady, RspValid, RspData, DbgData, DbgScanBusy, DbgScanValid
    );
    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, DbgAddr, DbgScanStart, DbgScanLen,
        output ReqReady, RspValid, RspData, DbgData, DbgScanBusy, DbgScanValid
    );
endinterface

// File: rtl/ram_arbiter.sv
// Dual-port RAM: port A shared round-robin by NCH requesters, port B a
// read-only debug port with single-read and auto-incrementing scan modes.
module ram_arbiter #(
    parameter int DW  = 16,
    parameter int AW  = 15,
    parameter int NCH = 2,
    parameter int LW  = 8
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);
    localparam int DEPTH = 2**AW;
    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {IDLE, SCAN} scan_state_e;

    logic [DW-1:0]  mem [DEPTH];

    logic [PW-1:0]  ptr_q, ptr_d, gidx;
    logic [NCH-1:0] gnt, rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_data_q, dbg_data_q;
    logic           acc, a_wr;
    logic [AW-1:0]  a_addr, b_addr;
    logic [DW-1:0]  a_wdata;
    int             best;

    scan_state_e    state_q, state_d;
    logic [AW-1:0]  scan_ptr_q, scan_ptr_d;
    logic [LW-1:0]  scan_cnt_q, scan_cnt_d;
    logic           scan_valid_q, scan_valid_d;

    // Winner is the valid channel with the smallest cyclic distance from ptr_q.
    always_comb begin
        best    = NCH;
        gidx    = '0;
        gnt     = '0;
        a_addr  = '0;
        a_wdata = '0;
        a_wr    = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.ReqValid[c] && ((c - int'(ptr_q) + NCH) % NCH) < best) begin
                best = (c - int'(ptr_q) + NCH) % NCH;
                gidx = PW'(c);
            end
        end
        acc = (best < NCH);
        for (int c = 0; c < NCH; c++) begin
            if (acc && gidx == PW'(c)) begin
                gnt[c]  = 1'b1;
                a_addr  = bus.ReqAddr[c*AW +: AW];
                a_wdata = bus.ReqWData[c*DW +: DW];
                a_wr    = bus.ReqWrite[c];
            end
        end
        ptr_d = ptr_q;
        if (acc) ptr_d = (gidx == PW'(NCH-1)) ? '0 : gidx + 1'b1;
        rsp_valid_d = (acc && !a_wr) ? gnt : '0;
    end

    always_comb begin
        state_d      = state_q;
        scan_ptr_d   = scan_ptr_q;
        scan_cnt_d   = scan_cnt_q;
        scan_valid_d = 1'b0;
        b_addr       = bus.DbgAddr;
        case (state_q)
            IDLE: if (bus.DbgScanStart && bus.DbgScanLen != '0) begin
                state_d    = SCAN;
                scan_ptr_d = bus.DbgAddr;
                scan_cnt_d = bus.DbgScanLen;
            end
            SCAN: begin
                b_addr       = scan_ptr_q;
                scan_valid_d = 1'b1;
                scan_ptr_d   = scan_ptr_q + 1'b1;
                scan_cnt_d   = scan_cnt_q - 1'b1;
                if (scan_cnt_q == LW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (acc && a_wr) mem[a_addr] <= a_wdata;
    end

    // Both read ports sample mem before this edge's write lands (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            dbg_data_q   <= '0;
            state_q      <= IDLE;
            scan_ptr_q   <= '0;
            scan_cnt_q   <= '0;
            scan_valid_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            if (acc && !a_wr) rsp_data_q <= mem[a_addr];
            dbg_data_q   <= mem[b_addr];
            state_q      <= state_d;
            scan_ptr_q   <= scan_ptr_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_valid_q <= scan_valid_d;
        end
    end

    assign bus.ReqReady     = gnt;
    assign bus.RspValid     = rsp_valid_q;
    assign bus.RspData      = rsp_data_q;
    assign bus.DbgData      = dbg_data_q;
    assign bus.DbgScanBusy  = (state_q == SCAN);
    assign bus.DbgScanValid = scan_valid_q;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Parametrised successor to the core-plus-dual-port-RAM arrangement: one inferred true dual-port synchronous RAM, generalised in data/address width.
- Port A is shared by NCH requesters (core, DMA, loader) through a round-robin arbiter with a valid/ready handshake.
- Port B is a read-only debug port with a single-read mode and an auto-incrementing burst scan mode.
- Sits between CoreTop-class masters and memory at the top level; replaces the direct core-to-RAM hookup.

Parameters:
- DW, 16, data width in bits.
- AW, 15, address width; DEPTH = 2**AW words.
- NCH, 2, number of port-A requester channels (1..8).
- LW, 8, width of the scan length field.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ReqValid  in  NCH  per-channel request valid.
- ReqWrite  in  NCH  per-channel 1=write, 0=read.
- ReqAddr  in  NCH*AW  per-channel address; channel i at [i*AW +: AW].
- ReqWData  in  NCH*DW  per-channel write data; channel i at [i*DW +: DW].
- ReqReady  out  NCH  one-hot grant; request accepted when ReqValid[i] && ReqReady[i].
- RspValid  out  NCH  one-hot read-data valid, one cycle after an accepted read.
- RspData  out  DW  read data for the channel flagged by RspValid.
- DbgAddr  in  AW  single-read address / scan base address.
- DbgData  out  DW  port-B read data.
- DbgScanStart  in  1  pulse; starts a scan at DbgAddr.
- DbgScanLen  in  LW  number of words to scan.
- DbgScanBusy  out  1  high while a scan is in progress.
- DbgScanValid  out  1  high when DbgData holds a scan word.

Behaviour:
- Reset (async assert): ReqReady, RspValid, RspData, DbgData, DbgScanBusy and DbgScanValid all 0; round-robin pointer = 0; scan FSM in IDLE. RAM contents are not cleared.
- Arbitration:
  - ReqReady is combinational from ReqValid and the pointer.
  - Grant goes to the first valid channel at or after the pointer, in cyclic order.
  - ReqReady is all-zero when no request is valid.
  - After any grant to channel g, the pointer becomes (g+1) mod NCH. With no grant, the pointer holds.
  - At most one port-A access per cycle.
- Write: the RAM word is updated at the accepting edge; no response is issued.
- Read:
  - RspValid[g] is registered high for exactly one cycle, on the cycle after acceptance.
  - RspData = the RAM value at acceptance, which includes any write accepted in earlier cycles.
  - RspData holds its value when RspValid is low.
- Back-to-back requests: one access per cycle is sustained, and read responses are fully pipelined.
- Fairness: with all channels continuously valid, grants rotate 0,1,..,NCH-1. No channel waits more than NCH-1 cycles.
- Port B, scan FSM IDLE (single-read mode): DbgData is registered every cycle as RAM[DbgAddr] (1-cycle latency); DbgScanValid = 0.
- Port A/B collision: port B is read-first. A same-cycle port-A write to the same address returns the old data on DbgData; the new data is visible the next cycle.
- Scan FSM, IDLE -> SCAN:
  - Triggered by DbgScanStart with DbgScanLen != 0.
  - Latches ScanPtr = DbgAddr and ScanCnt = DbgScanLen.
  - DbgScanBusy goes high on the next cycle.
- Scan FSM, IDLE with DbgScanStart and DbgScanLen == 0: no-op; stay in IDLE; busy never asserts.
- Scan FSM, SCAN:
  - Each cycle: read RAM[ScanPtr], then ScanPtr = (ScanPtr+1) mod DEPTH (wraps at DEPTH-1 -> 0), then ScanCnt decrements.
  - DbgScanValid is high one cycle after each scan read, exactly DbgScanLen pulses in consecutive cycles.
  - DbgScanBusy falls in the same cycle the last DbgScanValid is output.
  - The FSM then returns to IDLE.
- DbgScanStart while busy is ignored.
- Port-A traffic is unaffected by scans.
- Async reset mid-scan aborts immediately: busy/valid 0, FSM IDLE.
- Arithmetic: address increment is modulo 2**AW; ScanCnt is LW bits, unsigned.

Test Plan:
1. Reset, then ch0 writes 0xBEEF @0x0010, then ch1 reads @0x0010 -> ch1 ReqReady in its request cycle; RspValid=2'b10 next cycle with RspData=0xBEEF.
2. NCH=2, both channels read continuously for 6 cycles -> grants alternate 01,10,01,10,...; each RspValid follows its grant by exactly 1 cycle.
3. Same cycle: port-A write 0x1234 @0x0005 with DbgAddr=0x0005, where old value = 0x0000 -> DbgData=0x0000 next cycle, 0x1234 the cycle after.
4. Preload @0x7FFE..0x7FFF and @0x0000..0x0001 with 1,2,3,4; scan start DbgAddr=0x7FFE, Len=4 -> DbgScanValid high 4 consecutive cycles with DbgData 1,2,3,4 (address wraps); busy drops with the 4th valid.
5. Scan with Len=0 -> no busy, no valid; DbgScanStart during a busy Len=8 scan -> ignored, still exactly 8 valids.
6. Assert rst at the 3rd word of a Len=10 scan, with a read pending on ch0 -> busy, valid and RspValid all 0 at once; after release, pointer=0 and a new scan runs normally.
